tcp_rx_payload_commit: RTL

- Sits directly downstream of the TCP RX pipeline; consumes its per-packet result (`flowid`, accept flag, small-payload-buffer entry).
- Accepted payloads are copied chunk-by-chunk from the small payload buffer into the flow's RX ring.
- Keeps a per-flow commit pointer, frees the source buffer slot, then notifies the app side with the new committed tail.
- Rejected packets, and packets without payload, only have their buffer slot freed; no notification is sent.

---
 rtl/tcp_rx_payload_commit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tcp_rx_payload_commit.sv
// Copies accepted TCP RX payloads from the small payload buffer into per-flow RX rings,
// advances the flow's commit pointer, frees the buffer slot and notifies the app side.
module tcp_rx_payload_commit #(
  parameter int FLOWID_W   = 3,
  parameter int MAX_FLOWS  = 8,
  parameter int RX_PTR_W   = 14,
  parameter int BUF_ADDR_W = 16,
  parameter int LEN_W      = 16,
  parameter int DATA_W     = 256,
  localparam int DATA_BYTES = DATA_W / 8,
  localparam int BYTES_W    = $clog2(DATA_BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  input  logic [FLOWID_W-1:0]   in_flowid,
  input  logic                  in_accept,
  input  logic                  in_payload_val,
  input  logic [BUF_ADDR_W-1:0] in_payload_addr,
  input  logic [LEN_W-1:0]      in_payload_size,
  output logic                  in_rdy,
  output logic                  src_rd_req_val,
  output logic [BUF_ADDR_W-1:0] src_rd_req_addr,
  input  logic                  src_rd_req_rdy,
  input  logic                  src_rd_resp_val,
  input  logic [DATA_W-1:0]     src_rd_resp_data,
  output logic                  src_rd_resp_rdy,
  output logic                  dst_wr_req_val,
  output logic [FLOWID_W-1:0]   dst_wr_req_flowid,
  output logic [RX_PTR_W-1:0]   dst_wr_req_addr,
  output logic [DATA_W-1:0]     dst_wr_req_data,
  output logic [BYTES_W-1:0]    dst_wr_req_bytes,
  input  logic                  dst_wr_req_rdy,
  output logic                  free_req_val,
  output logic [BUF_ADDR_W-1:0] free_req_addr,
  output logic [LEN_W-1:0]      free_req_size,
  input  logic                  free_req_rdy,
  output logic                  commit_notif_val,
  output logic [FLOWID_W-1:0]   commit_notif_flowid,
  output logic [RX_PTR_W:0]     commit_notif_tail,
  input  logic                  commit_notif_rdy
);

  // Handshake rule on every port: a transfer happens on a rising edge where val && rdy;
  // a val asserted here stays asserted with stable payload until it is taken, and no val
  // is derived from its own rdy.
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR, FREE, NOTIF} state_t;

  state_t                state_q;
  logic                  run_q;
  logic                  commit_q;
  logic [FLOWID_W-1:0]   flowid_q;
  logic [BUF_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]      size_q;
  logic [BUF_ADDR_W-1:0] src_addr_q;
  logic [LEN_W-1:0]      remaining_q;
  logic [DATA_W-1:0]     data_q;
  logic [RX_PTR_W:0]     ptr_q [MAX_FLOWS];
  logic [BYTES_W-1:0]    chunk;

  always_comb begin
    chunk = BYTES_W'(DATA_BYTES);
    if (remaining_q < LEN_W'(DATA_BYTES)) chunk = remaining_q[BYTES_W-1:0];
  end

  // run_q keeps in_rdy low while reset is held and releases it on the first clock after.
  assign in_rdy              = run_q && (state_q == IDLE);
  assign src_rd_req_val      = (state_q == RD_REQ);
  assign src_rd_req_addr     = src_addr_q;
  assign src_rd_resp_rdy     = (state_q == RD_RESP);
  assign dst_wr_req_val      = (state_q == WR);
  assign dst_wr_req_flowid   = flowid_q;
  assign dst_wr_req_addr     = ptr_q[flowid_q][RX_PTR_W-1:0];
  assign dst_wr_req_data     = data_q;
  assign dst_wr_req_bytes    = chunk;
  assign free_req_val        = (state_q == FREE);
  assign free_req_addr       = addr_q;
  assign free_req_size       = size_q;
  assign commit_notif_val    = (state_q == NOTIF);
  assign commit_notif_flowid = flowid_q;
  assign commit_notif_tail   = ptr_q[flowid_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      commit_q    <= 1'b0;
      flowid_q    <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      src_addr_q  <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      for (int i = 0; i < MAX_FLOWS; i++) ptr_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (in_rdy && in_val) begin
            flowid_q    <= in_flowid;
            addr_q      <= in_payload_addr;
            size_q      <= in_payload_size;
            src_addr_q  <= in_payload_addr;
            remaining_q <= in_payload_size;
            if (in_accept && in_payload_val && (in_payload_size != '0)) begin
              commit_q <= 1'b1;
              state_q  <= RD_REQ;
            end else if (in_payload_val) begin
              commit_q <= 1'b0;
              state_q  <= FREE;
            end
          end
        end
        RD_REQ: if (src_rd_req_rdy) state_q <= RD_RESP;
        RD_RESP: begin
          if (src_rd_resp_val) begin
            data_q  <= src_rd_resp_data;
            state_q <= WR;
          end
        end
        WR: begin
          if (dst_wr_req_rdy) begin
            // Pointer wraps modulo 2**(RX_PTR_W+1); the top bit is the ring wrap flag.
            ptr_q[flowid_q] <= ptr_q[flowid_q] + (RX_PTR_W+1)'(chunk);
            remaining_q     <= remaining_q - LEN_W'(chunk);
            src_addr_q      <= src_addr_q + BUF_ADDR_W'(DATA_BYTES);
            state_q         <= (remaining_q == LEN_W'(chunk)) ? FREE : RD_REQ;
          end
        end
        FREE:    if (free_req_rdy) state_q <= commit_q ? NOTIF : IDLE;
        NOTIF:   if (commit_notif_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
